// File: rtl/mmind_pkg.sv
// rtl/mmind_pkg.sv - shared state type and default parameters for the code-breaking game
package mmind_pkg;

    localparam int DEF_PEGS      = 4;
    localparam int DEF_SYM_W     = 2;
    localparam int DEF_MAX_TRIES = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_EXACT,
        ST_NEAR,
        ST_WON,
        ST_LOST
    } state_t;

endpackage

// File: rtl/mmind_param_btn_edge.sv
// rtl/mmind_param_btn_edge.sv - registered rising-edge detector for a level button
//
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   btn_i  level button input
//   rise_o high in the cycle the button is high and was low the cycle before
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    // Previous value resets high so a button held through reset release
    // does not look like a fresh press.
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= btn_i;
        end
    end

    assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/mmind_param.sv
// rtl/mmind_param.sv - parameterised code-breaking game scorer with sequential scan
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   setans_btn         rising edge loads switches as the answer
//   guess_btn          rising edge submits switches as a guess
//   switches           packed code, position k = bits [k*SYM_W +: SYM_W]
//   exact, near        score of the last completed guess
//   attempts           guesses completed since the answer was loaded
//   busy               scan in progress
//   done               one-cycle pulse when the score outputs update
//   win, lose          game-over flags
module mmind_param
    import mmind_pkg::*;
#(
    parameter  int PEGS      = DEF_PEGS,
    parameter  int SYM_W     = DEF_SYM_W,
    parameter  int MAX_TRIES = DEF_MAX_TRIES,
    localparam int CNT_W     = $clog2(PEGS + 1),
    localparam int TRY_W     = $clog2(MAX_TRIES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  setans_btn,
    input  logic                  guess_btn,
    input  logic [PEGS*SYM_W-1:0] switches,
    output logic [CNT_W-1:0]      exact,
    output logic [CNT_W-1:0]      near,
    output logic [TRY_W-1:0]      attempts,
    output logic                  busy,
    output logic                  done,
    output logic                  win,
    output logic                  lose
);

    localparam int IDX_W  = (PEGS > 1) ? $clog2(PEGS) : 1;
    localparam int CODE_W = PEGS * SYM_W;

    logic setans_rise;
    logic guess_rise;

    btn_edge u_setans_edge (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (setans_btn),
        .rise_o (setans_rise)
    );

    btn_edge u_guess_edge (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (guess_btn),
        .rise_o (guess_rise)
    );

    state_t           state_q;
    logic [CODE_W-1:0] ans_q;
    logic [CODE_W-1:0] gs_q;
    logic [PEGS-1:0]   ans_used_q;
    logic [PEGS-1:0]   gs_used_q;
    logic [IDX_W-1:0]  i_q;
    logic [IDX_W-1:0]  j_q;
    logic [CNT_W-1:0]  exact_work_q;
    logic [CNT_W-1:0]  near_work_q;
    logic [CNT_W-1:0]  exact_q;
    logic [CNT_W-1:0]  near_q;
    logic [TRY_W-1:0]  attempts_q;
    logic              busy_q;
    logic              done_q;
    logic              win_q;
    logic              lose_q;

    // One symbol pair is examined per cycle, addressed by the index counters.
    logic [SYM_W-1:0] ans_sym_i;
    logic [SYM_W-1:0] ans_sym_j;
    logic [SYM_W-1:0] gs_sym_i;
    logic             exact_hit;
    logic             near_hit;
    logic             last_i;
    logic             last_j;
    logic [CNT_W-1:0] near_d;
    logic [TRY_W-1:0] attempts_d;
    logic             load_ans;

    assign ans_sym_i = ans_q[i_q*SYM_W +: SYM_W];
    assign ans_sym_j = ans_q[j_q*SYM_W +: SYM_W];
    assign gs_sym_i  = gs_q[i_q*SYM_W +: SYM_W];
    assign exact_hit = (ans_sym_i == gs_sym_i);
    assign near_hit  = !gs_used_q[i_q] && !ans_used_q[j_q] && (gs_sym_i == ans_sym_j);
    assign last_i    = (i_q == IDX_W'(PEGS - 1));
    assign last_j    = (j_q == IDX_W'(PEGS - 1));

    // The final NEAR cycle may itself score, so the published count includes it.
    assign near_d     = near_hit ? near_work_q + CNT_W'(1) : near_work_q;
    assign attempts_d = attempts_q + TRY_W'(1);

    // Answer load takes priority over a simultaneous guess; scans ignore it.
    assign load_ans = setans_rise &&
                      (state_q == ST_IDLE || state_q == ST_READY ||
                       state_q == ST_WON  || state_q == ST_LOST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ans_q        <= '0;
            gs_q         <= '0;
            ans_used_q   <= '0;
            gs_used_q    <= '0;
            i_q          <= '0;
            j_q          <= '0;
            exact_work_q <= '0;
            near_work_q  <= '0;
            exact_q      <= '0;
            near_q       <= '0;
            attempts_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_ans) begin
                ans_q      <= switches;
                attempts_q <= '0;
                exact_q    <= '0;
                near_q     <= '0;
                win_q      <= 1'b0;
                lose_q     <= 1'b0;
                state_q    <= ST_READY;
            end else begin
                case (state_q)
                    ST_READY: begin
                        if (guess_rise) begin
                            gs_q         <= switches;
                            ans_used_q   <= '0;
                            gs_used_q    <= '0;
                            exact_work_q <= '0;
                            near_work_q  <= '0;
                            i_q          <= '0;
                            j_q          <= '0;
                            busy_q       <= 1'b1;
                            state_q      <= ST_EXACT;
                        end
                    end
                    ST_EXACT: begin
                        if (exact_hit) begin
                            exact_work_q   <= exact_work_q + CNT_W'(1);
                            ans_used_q[i_q] <= 1'b1;
                            gs_used_q[i_q]  <= 1'b1;
                        end
                        if (last_i) begin
                            i_q     <= '0;
                            j_q     <= '0;
                            state_q <= ST_NEAR;
                        end else begin
                            i_q <= i_q + IDX_W'(1);
                        end
                    end
                    ST_NEAR: begin
                        if (near_hit) begin
                            near_work_q     <= near_d;
                            gs_used_q[i_q]  <= 1'b1;
                            ans_used_q[j_q] <= 1'b1;
                        end
                        if (!last_j) begin
                            j_q <= j_q + IDX_W'(1);
                        end else if (!last_i) begin
                            j_q <= '0;
                            i_q <= i_q + IDX_W'(1);
                        end else begin
                            j_q        <= '0;
                            i_q        <= '0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            exact_q    <= exact_work_q;
                            near_q     <= near_d;
                            attempts_q <= attempts_d;
                            if (exact_work_q == CNT_W'(PEGS)) begin
                                win_q   <= 1'b1;
                                state_q <= ST_WON;
                            end else if (attempts_d == TRY_W'(MAX_TRIES)) begin
                                lose_q  <= 1'b1;
                                state_q <= ST_LOST;
                            end else begin
                                state_q <= ST_READY;
                            end
                        end
                    end
                    ST_IDLE, ST_WON, ST_LOST: begin
                        state_q <= state_q;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign exact    = exact_q;
    assign near     = near_q;
    assign attempts = attempts_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign win      = win_q;
    assign lose     = lose_q;

endmodule
